and16_arbiter: RTL and testbench
================================

AND16_ARBITER -- requirements
Module: and16_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the single and16 reduction unit.
REQ-002 Parameter WIDTH, default 16: operand width; fixed at 16 to match and16.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_data  input  NUM_REQ*WIDTH  operands; requester i at bits [16i+15:16i].
REQ-007 req_ready  output  NUM_REQ  one-hot grant; transfer for requester i when req_valid[i] and req_ready[i] are both high.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_out  output  1  AND-reduction of the granted operand.
REQ-011 resp_id  output  clog2(NUM_REQ)  index of the requester that owns resp_out.
REQ-012 busy  output  1  high whenever resp_valid is high.

Function
REQ-013 FSM states SHALL be IDLE and RESP only.
REQ-014 IDLE: if any req_valid is high, grant exactly one requester, capture its operand through and16, go to RESP next cycle; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps from NUM_REQ-1 to 0, first valid requester wins.
REQ-016 After a grant to requester k, rr_ptr SHALL become (k+1) mod NUM_REQ; rr_ptr SHALL be unchanged when no grant occurs.
REQ-017 Latency SHALL be one cycle: an operand accepted in cycle N gives resp_valid=1 in cycle N+1.
REQ-018 RESP: resp_valid=1; resp_out and resp_id SHALL hold stable until resp_ready is sampled high.
REQ-019 In RESP with resp_ready=0, req_ready SHALL be all zeros.
REQ-020 In RESP with resp_ready=1 and any req_valid high, a new grant SHALL occur in the same cycle and the FSM SHALL stay in RESP with new data, giving one result per cycle.
REQ-021 In RESP with resp_ready=1 and no req_valid, the FSM SHALL return to IDLE.
REQ-022 req_ready SHALL be combinational from req_valid, rr_ptr, state and resp_ready, with at most one bit high.
REQ-023 A requester SHALL NOT be granted when its req_valid is low.
REQ-024 resp_out SHALL equal 1 only when all 16 bits of the captured operand are 1.

Reset
REQ-025 With rst high at a clock edge: state=IDLE, rr_ptr=0, resp_valid=0, resp_out=0, resp_id=0, busy=0.
REQ-026 While rst is high, req_ready SHALL be all zeros.
REQ-027 Reset asserted in RESP SHALL discard the pending result without a handshake.

Structure
REQ-028 Package and16_pkg SHALL hold NUM_REQ, WIDTH, the ID width constant and the state enum type.
REQ-029 The reduction SHALL be one instance of the existing and16 sub-module, fed by a NUM_REQ:1 operand mux.
REQ-030 The arbiter SHALL contain no other arithmetic beyond the round-robin pointer increment.

Verification
REQ-031 Single request: req_valid=0001, data0=FFFF -> req_ready=0001 in the same cycle; next cycle resp_valid=1, resp_out=1, resp_id=0.
REQ-032 Zero and near-full operands: data=0000, 0001, FFFE and AAAA each give resp_out=0; data FFFF gives resp_out=1.
REQ-033 Fairness with all four requesters valid continuously and resp_ready=1: grants follow 0,1,2,3,0 and results arrive one per cycle.
REQ-034 Back-pressure: hold resp_ready=0 for 3 cycles -> req_ready=0000 and resp_out/resp_id stable; release -> next grant in the same cycle.
REQ-035 Pointer wrap: rr_ptr=3 with req_valid=1001 -> grant requester 3, then requester 0.
REQ-036 Reset mid-operation: assert rst in RESP -> next cycle resp_valid=0, rr_ptr=0, and req_valid=0010 is granted only after rst deasserts.

Source files
------------

// File: rtl/and16_pkg.sv
// Shared constants and FSM state type for the and16 round-robin arbiter.
package and16_pkg;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage : and16_pkg

// File: rtl/and16.sv
// 16-bit AND reduction: y is high only when every operand bit is high.
module and16 (
    input  logic [15:0] a,
    output logic        y
);

    assign y = &a;

endmodule : and16

// File: rtl/and16_arbiter.sv
// Round-robin arbiter sharing one and16 reduction among NUM_REQ requesters;
// one-cycle latency, one result per cycle while the consumer keeps up.
module and16_arbiter #(
    parameter int NUM_REQ = and16_pkg::NUM_REQ,
    parameter int WIDTH   = and16_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_out,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       busy
);

    import and16_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic             can_accept;
    logic             grant;
    logic [WIDTH-1:0] grant_data;
    logic             and_y;

    // Two-pass search: first from rr_ptr upward, then wrap to index 0.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        grant_found = 1'b0;
        grant_id    = '0;
        grant_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
                grant_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
                grant_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A slot opens when idle, or when the pending result is being consumed.
    assign can_accept = !rst && ((state == IDLE) || resp_ready);
    assign grant      = can_accept && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (grant) state_next = RESP;
            RESP: if (resp_ready) state_next = grant ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    and16 u_and16 (
        .a (grant_data),
        .y (and_y)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            resp_out <= 1'b0;
            resp_id  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                resp_out <= and_y;
                resp_id  <= grant_id;
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = resp_valid;

endmodule : and16_arbiter

// File: tb/tb_and16_arbiter.sv
// Directed, table-driven bench for and16_arbiter with hand-written
// sequences for back-pressure, pointer wrap and reset in RESP.
module tb_and16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_out;
    logic [1:0]  resp_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [63:0] data;
        logic        rready;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic        exp_out;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    and16_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [63:0] d,
                                input logic rr, input logic [3:0] er, input logic erv,
                                input logic eo, input logic [1:0] eid);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.rready = rr;
        x.exp_ready = er; x.exp_rv = erv; x.exp_out = eo; x.exp_id = eid;
        return x;
    endfunction

    // Drive one cycle's inputs after the falling edge, check before the rising edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst        = v.rst;
        req_valid  = v.valid;
        req_data   = v.data;
        resp_ready = v.rready;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        check({tag, " resp_valid"}, 32'(resp_valid), 32'(v.exp_rv));
        check({tag, " busy"}, 32'(busy), 32'(v.exp_rv));
        if (v.exp_rv) begin
            check({tag, " resp_out"}, 32'(resp_out), 32'(v.exp_out));
            check({tag, " resp_id"}, 32'(resp_id), 32'(v.exp_id));
        end
    endtask

    function automatic logic [63:0] d0(input logic [15:0] x);
        return {48'hFFFF_FFFF_FFFF, x};
    endfunction

    localparam logic [63:0] FAIR = {16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF};
    localparam logic [63:0] BP   = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    localparam logic [63:0] WRAP = {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_out", 32'(resp_out), 32'd0);
        check("reset resp_id", 32'(resp_id), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);

        // Single request, then operand patterns streamed on requester 0.
        tbl.push_back(mk(0, 4'b0001, d0(16'hFFFF), 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, d0(16'h0000), 1, 4'b0001, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0001, d0(16'h0001), 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, d0(16'hFFFE), 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, d0(16'hAAAA), 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, d0(16'hFFFF), 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, d0(16'h0000), 1, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, d0(16'h0000), 0, 4'b0000, 0, 0, 0));
        // Reset, then fairness with all requesters valid.
        tbl.push_back(mk(1, 4'b1111, FAIR, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, FAIR, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, FAIR, 1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, FAIR, 1, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, FAIR, 1, 4'b1000, 1, 1, 2));
        tbl.push_back(mk(0, 4'b1111, FAIR, 1, 4'b0001, 1, 0, 3));
        tbl.push_back(mk(0, 4'b0000, FAIR, 1, 4'b0000, 1, 1, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Back-pressure: three stalled cycles, then release grants in the same cycle.
        step(mk(0, 4'b0100, BP, 0, 4'b0100, 0, 0, 0), "bp grant");
        for (int i = 0; i < 3; i++)
            step(mk(0, 4'b1111, BP, 0, 4'b0000, 1, 1, 2), $sformatf("bp stall%0d", i));
        step(mk(0, 4'b1111, BP, 1, 4'b1000, 1, 1, 2), "bp release");
        step(mk(0, 4'b0000, BP, 1, 4'b0000, 1, 0, 3), "bp drain");

        // Pointer wrap: rr_ptr reaches 3, then 3 wins before 0.
        step(mk(0, 4'b0100, WRAP, 1, 4'b0100, 0, 0, 0), "wrap set");
        step(mk(0, 4'b1001, WRAP, 1, 4'b1000, 1, 1, 2), "wrap g3");
        step(mk(0, 4'b1001, WRAP, 1, 4'b0001, 1, 0, 3), "wrap g0");
        step(mk(0, 4'b0000, WRAP, 1, 4'b0000, 1, 1, 0), "wrap drain");

        // Reset while in RESP discards the result and clears rr_ptr.
        step(mk(0, 4'b0010, WRAP, 0, 4'b0010, 0, 0, 0), "rst grant");
        step(mk(1, 4'b0010, WRAP, 0, 4'b0000, 1, 0, 1), "rst in resp");
        step(mk(1, 4'b0010, WRAP, 0, 4'b0000, 0, 0, 0), "rst held");
        step(mk(0, 4'b0110, WRAP, 0, 4'b0010, 0, 0, 0), "rst after");
        step(mk(0, 4'b0000, WRAP, 1, 4'b0000, 1, 0, 1), "rst result");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and16_arbiter
